// File: rtl/display_scan_3digits_if.sv
// rtl/display_scan_3digits_if.sv - digit inputs and display outputs of the 3-digit scanner
interface display_scan_3digits_if;
  logic [3:0] h1;
  logic [3:0] h2;
  logic [3:0] h3;
  logic       load;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame;
  logic       pending;

  modport master (
    output h1, h2, h3, load, blank_lz,
    input  an, seg, frame, pending
  );

  modport slave (
    input  h1, h2, h3, load, blank_lz,
    output an, seg, frame, pending
  );
endinterface

// File: rtl/display_scan_3digits.sv
// rtl/display_scan_3digits.sv - double-buffered, time-multiplexed 3-digit 7-segment driver
module display_scan_3digits #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  display_scan_3digits_if.slave bus
);

  localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2} slot_t;

  logic [CW-1:0] cnt;
  logic          tick;
  slot_t         idx;
  logic [3:0]    d1, d2, d3;
  logic [11:0]   pbuf;
  logic          pflag;
  logic [3:0]    c1;
  logic          blank1, blank2;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Slot 0 shows the value being committed on the same edge, so look through the buffer.
  assign c1     = pflag ? pbuf[3:0] : d1;
  assign blank1 = bus.blank_lz && (d3 == 4'h0) && (d2 == 4'h0);
  assign blank2 = bus.blank_lz && (d3 == 4'h0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= SLOT0;
      d1    <= 4'h0;
      d2    <= 4'h0;
      d3    <= 4'h0;
      pbuf  <= 12'h000;
      pflag <= 1'b0;
      bus.an    <= 4'b1111;
      bus.seg   <= 7'b1111111;
      bus.frame <= 1'b0;
    end else begin
      bus.frame <= 1'b0;
      if (tick) begin
        case (idx)
          SLOT0: begin
            if (pflag) begin
              {d3, d2, d1} <= pbuf;
              pflag        <= 1'b0;
            end
            bus.an    <= 4'b1110;
            bus.seg   <= seg7(c1);
            bus.frame <= 1'b1;
            idx       <= SLOT1;
          end
          SLOT1: begin
            bus.an  <= blank1 ? 4'b1111 : 4'b1101;
            bus.seg <= blank1 ? 7'b1111111 : seg7(d2);
            idx     <= SLOT2;
          end
          SLOT2: begin
            bus.an  <= blank2 ? 4'b1111 : 4'b1011;
            bus.seg <= blank2 ? 7'b1111111 : seg7(d3);
            idx     <= SLOT0;
          end
          default: begin
            bus.an  <= 4'b1111;
            bus.seg <= 7'b1111111;
            idx     <= SLOT0;
          end
        endcase
      end
      // A load on the commit edge lands after the commit, keeping the new value pending.
      if (bus.load) begin
        pbuf  <= {bus.h3, bus.h2, bus.h1};
        pflag <= 1'b1;
      end
    end
  end

  assign bus.pending = pflag;

endmodule

// File: doc/display_scan_3digits.md
Name: display_scan_3digits

Overview:
- Consumes the three 4-bit digit nibbles (units, tens, hundreds) produced by the binary-to-digit converter.
- Drives a common-anode multiplexed 7-segment display by time-scanning those digits.
- Double-buffers the digits so a new value is only shown at a frame boundary, which prevents tearing.
- Optionally blanks leading zeros and hex-decodes each nibble, so 0-F are displayable.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot. Legal values are 1 or greater. With a 50 MHz clock the default gives 1 kHz per digit.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous reset, active-low
- h1  input  4  units nibble
- h2  input  4  tens nibble
- h3  input  4  hundreds nibble
- load  input  1  one-cycle strobe; capture h1..h3 into the pending buffer
- blank_lz  input  1  1 = blank leading zeros of h3/h2
- an  output  4  anode enables, active-low, registered; an[3] is always 1
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
- frame  output  1  one-cycle pulse when a new frame starts (digit 0 slot)
- pending  output  1  1 = captured value not yet committed to the display

Behaviour:

Reset (rst_n=0 sampled on a clk edge):
- Prescaler = 0; slot index idx = 0.
- Display registers d1/d2/d3 = 0; pending buffer = 0; pending flag = 0.
- Outputs: an = 4'b1111, seg = 7'b1111111, frame = 0.
- Reset mid-operation discards any pending value, and the scan restarts from scratch.

Prescaler:
- Counts 0..REFRESH_DIV-1, then wraps to 0.
- tick = 1 on cycles where count == REFRESH_DIV-1.
- With REFRESH_DIV = 1, tick is asserted every cycle.

Scan sequencer (3 states, SLOT0 -> SLOT1 -> SLOT2 -> SLOT0):
- The sequencer advances only on tick.
- On a tick edge, the outputs are loaded for the slot given by the current idx, then idx advances.
- The first tick after reset (REFRESH_DIV cycles after rst_n rises) shows slot 0.
- Slot 0: an = 1110, digit d1. Slot 1: an = 1101, digit d2. Slot 2: an = 1011, digit d3.
- Between ticks, an and seg hold their values.

Double buffer:
- load = 1 on an edge: pending buffer <= {h3,h2,h1}; pending flag <= 1.
  - A load while already pending overwrites the buffer; the last load wins.
- Commit happens on a tick edge with idx == 0:
  - If the pending flag is set, d1..d3 <= buffer and the flag clears.
  - The slot-0 output on that same edge already uses the committed values.
  - frame = 1 on that edge (for exactly 1 cycle), whether or not a commit occurred.
- load and commit on the same edge:
  - The commit uses the buffer contents from before the edge.
  - The new load value is captured into the buffer and the pending flag stays 1, so the new value is shown next frame.

Leading-zero blanking (evaluated on the committed d values):
- With blank_lz = 1:
  - Slot 2 is blanked if d3 == 0.
  - Slot 1 is blanked if d3 == 0 and d2 == 0.
  - Slot 0 is never blanked.
- A blanked slot drives an = 1111 and seg = 1111111 for its whole period; the sequencer still spends the slot time.
- With blank_lz = 0, no slot is blanked.

Segment decode (gfedcba, active-low):
- 0=1000000 1=1111001 2=0100100 3=0110000
- 4=0011001 5=0010010 6=0000010 7=1111000
- 8=0000000 9=0010000 A=0001000 b=0000011
- C=1000110 d=0100001 E=0000110 F=0001110

Timing and structure:
- All outputs are registered; there are no combinational input-to-output paths.
- Latency from a load to its first visible digit is at most 4*REFRESH_DIV cycles.

Test Plan:
All scenarios use REFRESH_DIV=4.
1. Reset:
   - Hold rst_n=0 for 3 cycles and release -> an=1111, seg=1111111, frame=0, pending=0 for cycles 1-3.
   - Cycle 4 (the first tick edge) -> an=1110, seg=1000000, frame=1.
2. Load and scan:
   - load with h3=0,h2=1,h1=5 and blank_lz=0 -> pending=1 until the next slot-0 tick, then pending=0.
   - Subsequent slots show an=1110/seg=0010010, then an=1101/seg=1111001, then an=1011/seg=1000000, repeating every 12 cycles.
3. Blanking:
   - Same value with blank_lz=1 -> slot 2 gives an=1111, seg=1111111; slots 0 and 1 unchanged.
   - Value 0,0,7 -> only slot 0 lit, seg=1111000.
4. Buffer races:
   - load 1,2,3, then load 0,0,9 before the commit -> display shows 9 (last load wins).
   - load asserted exactly on the commit edge -> the old buffer is shown, pending stays 1, and the new value appears at the next frame.
5. Hex decode and mid-frame reset:
   - load h1=4'hA, h2=4'hF -> seg=0001000 and seg=0001110 in their slots.
   - Assert rst_n=0 during slot 1 -> next edge gives an=1111, display registers cleared, pending=0.
6. REFRESH_DIV=1 instance:
   - an cycles 1110 -> 1101 -> 1011 on consecutive clocks.
   - frame pulses every 3rd cycle.
